// File: rtl/fdivsqrt_iter_sched.sv
// fdivsqrt_iter_sched: cycle sequencer for the radix-4 divide/sqrt recurrence.
// Accepts an operation, works out how many recurrence cycles the requested
// quotient width needs, drives the datapath init/iterate/j1/j2 strobes and
// then holds a completion handshake until the result consumer takes it.
module fdivsqrt_iter_sched #(
    parameter int DIVCOPIES = 2,
    parameter int MAXCYC    = 32,
    parameter int RBW       = 8,
    parameter int CW        = $clog2(MAXCYC + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           StartValid,
    output logic           StartReady,
    input  logic           SqrtE,
    input  logic           SpecialCase,
    input  logic [RBW-1:0] ResultBits,
    input  logic           Stall,
    input  logic           Flush,
    output logic           Init,
    output logic           IterEn,
    output logic           j1,
    output logic           j2,
    output logic [CW-1:0]  CycleCnt,
    output logic           Busy,
    output logic           DoneValid,
    input  logic           DoneReady
);

    // Quotient bits retired per clock across all chained radix-4 stages.
    localparam int BPC = 2 * DIVCOPIES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           sqrt_q;
    // Iterations already performed, saturating at 2; only used to place j1/j2.
    logic [1:0]     iters;

    logic [RBW:0]   n_raw;
    logic [CW-1:0]  n_cyc;
    logic           accept;

    // Recurrence cycle count: ceil(ResultBits / BPC), at least 1, at most MAXCYC.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        n_cyc = CW'(1);
        n_raw = ({1'b0, ResultBits} + (RBW + 1)'(BPC - 1)) / (RBW + 1)'(BPC);
        if (n_raw == '0)
            n_cyc = CW'(1);
        else if (n_raw > (RBW + 1)'(MAXCYC))
            n_cyc = CW'(MAXCYC);
        else
            n_cyc = CW'(n_raw);
    end

    // Handshake and datapath strobes; flush masks everything in its own cycle.
    always_comb begin
        StartReady = ~Flush & ((state == IDLE) | ((state == DONE) & DoneReady));
        accept     = StartValid & StartReady;
        Init       = accept;
        IterEn     = (state == ITER) & ~Stall & ~Flush;
        j1         = IterEn & sqrt_q & (iters == 2'd0);
        j2         = IterEn & sqrt_q & (iters == 2'd1);
        Busy       = (state != IDLE);
        DoneValid  = (state == DONE);
        CycleCnt   = cnt;
    end

    // Sequencer state, remaining-cycle counter and latched operation type.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sqrt_q <= 1'b0;
            iters  <= 2'd0;
        end else if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
            iters <= 2'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        sqrt_q <= SqrtE;
                        iters  <= 2'd0;
                        if (SpecialCase) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            state <= ITER;
                            cnt   <= n_cyc;
                        end
                    end else if ((state == DONE) && DoneReady) begin
                        state <= IDLE;
                    end
                end
                ITER: begin
                    if (!Stall) begin
                        if (iters != 2'd2)
                            iters <= iters + 2'd1;
                        if (cnt == CW'(1)) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
